// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron sequencer: FSM state encoding,
// default datapath widths and the ReLU gate.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ACT   = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam int W_DEF = 8;
    localparam int M_DEF = 18;

    // ReLU gate on a sign-extended accumulator: pass only strictly positive
    // values, so an exact zero maps to zero like any negative value.
    function automatic logic relu_pass(input logic signed [63:0] v);
        return v > 64'sd0;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// Combinational multiply-accumulate step: acc + sext(x*w).
// Saturating addition when NEURON_SATURATE_EN is defined, wrap-around otherwise.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int M = M_DEF
) (
    input  logic signed [M-1:0] acc,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] w,
    output logic signed [M-1:0] sum
);

    logic signed [2*W-1:0] prod;
    logic signed [M-1:0]   prod_ext;

    assign prod     = (2*W)'(x) * (2*W)'(w);
    assign prod_ext = M'(prod);

`ifdef NEURON_SATURATE_EN
    // Overflow only when both operands share a sign and the result flips it.
    function automatic logic signed [M-1:0] sat_add(input logic signed [M-1:0] a,
                                                    input logic signed [M-1:0] b);
        logic signed [M-1:0] r;
        r = a + b;
        if ((a[M-1] == b[M-1]) && (r[M-1] != a[M-1])) begin
            r = a[M-1] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
        end
        return r;
    endfunction

    assign sum = sat_add(acc, prod_ext);
`else
    assign sum = acc + prod_ext;
`endif

endmodule

// File: rtl/neuron_sequencer.sv
// Single-neuron evaluation controller: bias capture, N-beat MAC over a
// valid/ready stream, ReLU, and a held valid/ready result. Option: NEURON_SATURATE_EN.
module neuron_sequencer
    import neuron_pkg::*;
#(
    parameter int N = 4,
    parameter int W = W_DEF,
    parameter int M = M_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] bias,
    input  logic signed [W-1:0] x_data,
    input  logic signed [W-1:0] w_data,
    input  logic                x_valid,
    output logic                x_ready,
    output logic signed [M-1:0] y_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t              state;
    logic signed [M-1:0] acc;
    logic signed [M-1:0] mac_sum;
    logic signed [M-1:0] relu_y;
    logic [CW-1:0]       cnt;

    assign x_ready = (state == ACCUM);
    assign busy    = (state != IDLE);
    assign relu_y  = relu_pass(64'(acc)) ? acc : '0;

    neuron_mac #(.W(W), .M(M)) u_mac (
        .acc (acc),
        .x   (x_data),
        .w   (w_data),
        .sum (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= M'(bias);
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (x_valid) begin
                        acc <= mac_sum;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) state <= ACT;
                    end
                end
                ACT: begin
                    y_data  <= relu_y;
                    y_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    // Result (y_data) stays visible after the handshake.
                    if (y_ready) begin
                        y_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
